// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences every Data_memory access for the MEM stage and the debug unit,
// turning sub-word stores into read-modify-write. Define DATA_MEM_CTRL_DEBUG_EN for the debug port.
module data_mem_ctrl #(
  parameter int unsigned RAM_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_p_req,
  input  logic                  i_p_we,
  input  logic [1:0]            i_p_size,
  input  logic                  i_p_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_p_addr,
  input  logic [RAM_WIDTH-1:0]  i_p_wdata,
  output logic                  o_p_stall,
  output logic                  o_p_done,
  output logic                  o_p_err,
  output logic [RAM_WIDTH-1:0]  o_p_rdata,
  input  logic                  i_d_req,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  output logic                  o_d_valid,
  output logic [RAM_WIDTH-1:0]  o_d_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [RAM_WIDTH-1:0]  o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [RAM_WIDTH-1:0]  i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, P_WR, P_RD, P_RDV, P_RMW_RD, P_RMW_WR, D_RD, D_RDV
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  mis_q;
  logic                  done_q;
  logic [RAM_WIDTH-1:0]  wdata_q;
  logic [RAM_WIDTH-1:0]  merged;
  logic [RAM_WIDTH-1:0]  load_ext;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  req_word;
  logic                  req_half;
  logic                  req_mis;

  assign req_word = i_p_size[1];
  assign req_half = (i_p_size == 2'b01);
  assign req_mis  = (req_half & i_p_addr[0]) | (req_word & (i_p_addr[1:0] != 2'b00));

`ifdef DATA_MEM_CTRL_DEBUG_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             dvalid_q;
  logic             d_win;

  assign d_win = i_d_req & (~i_p_req | (starve_cnt >= STARVE_TH));

  // A debug request already being served is not counted as waiting.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && d_win) begin
      starve_cnt <= '0;
    end else if (i_d_req && state != D_RD && state != D_RDV && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign o_d_valid = dvalid_q;
  assign o_d_rdata = (state == D_RDV) ? i_mem_rdata : '0;
`else
  logic unused_dbg;
  assign unused_dbg = ^{i_d_req, i_d_addr};
  assign o_d_valid  = 1'b0;
  assign o_d_rdata  = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef DATA_MEM_CTRL_DEBUG_EN
      dvalid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DATA_MEM_CTRL_DEBUG_EN
      dvalid_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef DATA_MEM_CTRL_DEBUG_EN
          if (d_win) begin
            state  <= D_RD;
            addr_q <= {i_d_addr, 2'b00};
            mis_q  <= 1'b0;
          end else
`endif
          if (i_p_req) begin
            addr_q  <= i_p_addr;
            size_q  <= i_p_size;
            uns_q   <= i_p_unsigned;
            wdata_q <= i_p_wdata;
            mis_q   <= req_mis;
            // Misaligned accesses finish at once with the error flag and no memory write.
            if (req_mis) begin
              state  <= i_p_we ? P_WR : P_RDV;
              done_q <= 1'b1;
            end else if (!i_p_we) begin
              state <= P_RD;
            end else if (req_word) begin
              state  <= P_WR;
              done_q <= 1'b1;
            end else begin
              state <= P_RMW_RD;
            end
          end
        end
        P_RD: begin
          state  <= P_RDV;
          done_q <= 1'b1;
        end
        P_RMW_RD: begin
          state  <= P_RMW_WR;
          done_q <= 1'b1;
        end
`ifdef DATA_MEM_CTRL_DEBUG_EN
        D_RD: begin
          state    <= D_RDV;
          dvalid_q <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane_b = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{(RAM_WIDTH-8){lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_ext = {{(RAM_WIDTH-16){lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = i_mem_rdata;
    endcase
    merged = i_mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  assign o_mem_addr  = addr_q[ADDR_WIDTH+1:2];
  assign o_mem_wdata = (state == P_RMW_WR) ? merged : wdata_q;
  assign o_mem_we    = i_reset & ~mis_q & ((state == P_WR) | (state == P_RMW_WR));
  assign o_p_done    = done_q;
  assign o_p_err     = done_q & mis_q;
  assign o_p_rdata   = (state == P_RDV && !mis_q) ? load_ext : '0;
  assign o_p_stall   = i_p_req & ~done_q;

endmodule
